// File: rtl/line_fetch_if.sv
`default_nettype none
// ============================================================================
// line_fetch_if : command, local-memory and external-bus signals of line_fetch
// Rev 1.0
// ============================================================================
interface line_fetch_if #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
);
  localparam int TW = $clog2(list_depth);
  localparam int BW = $clog2(list_width);

  logic                  fetch_req;
  logic [1:0]            fetch_cmd;
  logic [TW-1:0]         fetch_tag;
  logic [addr_width-1:0] fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_done;

  logic                  mem_ren;
  logic [TW+BW-1:0]      mem_raddr;
  logic                  mem_rready;
  logic                  mem_rvalid;
  logic [data_width-1:0] mem_rdata;
  logic                  mem_wen;
  logic [TW+BW-1:0]      mem_waddr;
  logic [1:0]            mem_wpri;
  logic                  mem_wready;
  logic [data_width-1:0] mem_wdata;

  logic                  bus_req;
  logic                  bus_we;
  logic [addr_width-1:0] bus_addr;
  logic [BW-1:0]         bus_len;
  logic                  bus_gnt;
  logic                  bus_wvalid;
  logic [data_width-1:0] bus_wdata;
  logic                  bus_wlast;
  logic                  bus_wready;
  logic                  bus_rvalid;
  logic [data_width-1:0] bus_rdata;
  logic                  bus_rlast;
  logic                  bus_rready;
  logic                  proto_err;

  modport slave (
    input  fetch_req, fetch_cmd, fetch_tag, fetch_addr,
    output fetch_gnt, fetch_done,
    output mem_ren, mem_raddr, input mem_rready, mem_rvalid, mem_rdata,
    output mem_wen, mem_waddr, mem_wpri, mem_wdata, input mem_wready,
    output bus_req, bus_we, bus_addr, bus_len, input bus_gnt,
    output bus_wvalid, bus_wdata, bus_wlast, input bus_wready,
    input  bus_rvalid, bus_rdata, bus_rlast, output bus_rready,
    output proto_err
  );

  modport master (
    output fetch_req, fetch_cmd, fetch_tag, fetch_addr,
    input  fetch_gnt, fetch_done,
    input  mem_ren, mem_raddr, output mem_rready, mem_rvalid, mem_rdata,
    input  mem_wen, mem_waddr, mem_wpri, mem_wdata, output mem_wready,
    input  bus_req, bus_we, bus_addr, bus_len, output bus_gnt,
    input  bus_wvalid, bus_wdata, bus_wlast, output bus_wready,
    output bus_rvalid, bus_rdata, bus_rlast, input bus_rready,
    input  proto_err
  );
endinterface
`default_nettype wire

// File: rtl/line_fetch.sv
`default_nettype none
// ============================================================================
// line_fetch : moves one line between local data memory and the external bus
// Rev 1.0
// ============================================================================
module line_fetch #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  line_fetch_if.slave lf
);
  localparam int TW   = $clog2(list_depth);
  localparam int BW   = $clog2(list_width);
  localparam int OFFW = $clog2(list_width * data_width / 8);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(list_width - 1);
  localparam logic [addr_width-1:0] OFF_MASK  = addr_width'((64'd1 << OFFW) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, WB_ADDR, WB_RD, WB_WAIT, WB_SEND, FL_ADDR, FL_DATA, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic [data_width-1:0] beat_q, beat_d;
  logic                  perr_q, perr_d;
  logic                  is_last, fill_st, fill_xfer;

  assign is_last   = (cnt_q == LAST_BEAT);
  assign fill_st   = (state_q == FL_DATA);
  assign fill_xfer = fill_st && lf.bus_rvalid && lf.mem_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (lf.fetch_req) begin
          tag_d  = lf.fetch_tag;
          addr_d = lf.fetch_addr & ~OFF_MASK;
          cnt_d  = '0;
          if (lf.fetch_cmd[1])      state_d = DONE;
          else if (lf.fetch_cmd[0]) state_d = FL_ADDR;
          else                      state_d = WB_ADDR;
        end
      end
      WB_ADDR: if (lf.bus_gnt) state_d = WB_RD;
      WB_RD:   if (lf.mem_rready) state_d = WB_WAIT;
      WB_WAIT: begin
        if (lf.mem_rvalid) begin
          beat_d  = lf.mem_rdata;
          state_d = WB_SEND;
        end
      end
      WB_SEND: begin
        if (lf.bus_wready) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + BW'(1);
            state_d = WB_RD;
          end
        end
      end
      FL_ADDR: if (lf.bus_gnt) state_d = FL_DATA;
      FL_DATA: begin
        if (fill_xfer) begin
          // The beat counter, not bus_rlast, ends the burst; rlast only flags errors.
          if (lf.bus_rlast != is_last) perr_d = 1'b1;
          if (is_last) state_d = DONE;
          else         cnt_d   = cnt_q + BW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lf.fetch_gnt  = (state_q == IDLE);
  assign lf.fetch_done = (state_q == DONE);
  assign lf.bus_req    = (state_q == WB_ADDR) || (state_q == FL_ADDR);
  assign lf.bus_we     = (state_q == WB_ADDR);
  assign lf.bus_addr   = addr_q;
  assign lf.bus_len    = LAST_BEAT;
  assign lf.mem_ren    = (state_q == WB_RD);
  assign lf.mem_raddr  = {tag_q, cnt_q};
  assign lf.bus_wvalid = (state_q == WB_SEND);
  assign lf.bus_wdata  = beat_q;
  assign lf.bus_wlast  = (state_q == WB_SEND) && is_last;
  // Fill is a pass-through: memory backpressure is forwarded straight to the bus.
  assign lf.mem_wen    = fill_st && lf.bus_rvalid;
  assign lf.bus_rready = fill_st && lf.mem_wready;
  assign lf.mem_wdata  = fill_st ? lf.bus_rdata : '0;
  assign lf.mem_waddr  = {tag_q, cnt_q};
  assign lf.mem_wpri   = 2'b01;
  assign lf.proto_err  = perr_q;
endmodule
`default_nettype wire

// File: tb/tb_line_fetch.sv
`default_nettype none
// ============================================================================
// tb_line_fetch : directed stimulus with a queue scoreboard for line_fetch
// Rev 1.0
// ============================================================================
module tb_line_fetch;
  localparam int AW = 32, LD = 4, DW = 32, LW = 32;

  logic clk, rst_n;
  line_fetch_if #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) lf();
  line_fetch #(.addr_width(AW), .list_depth(LD), .data_width(DW), .list_width(LW)) dut (
    .clk(clk), .rst_n(rst_n), .lf(lf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [32:0] q_bus[$];   // {we, addr}
  logic [32:0] q_wb[$];    // {last, data}
  logic [38:0] q_mw[$];    // {waddr, data}
  longint      q_done[$];  // time of the edge that enters DONE, -1 = untimed
  logic [31:0] tbmem [0:127];
  bit stall_en = 0, wr_toggle = 0;
  int stall_beat = 0, stall_len = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++; n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Scoreboard monitor
  logic held_q = 1'b0;
  logic [32:0] held_v = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held_q = 1'b0;
    end else begin
      if (lf.bus_req && lf.bus_gnt) begin
        if (q_bus.size() == 0) flag("unexpected_bus_req");
        else chk("bus_addr_we", {lf.bus_we, lf.bus_addr}, q_bus.pop_front());
      end
      if (lf.bus_wvalid) begin
        if (held_q) chk("wbeat_stable", {lf.bus_wlast, lf.bus_wdata}, held_v);
        if (lf.bus_wready) begin
          if (q_wb.size() == 0) flag("unexpected_wbeat");
          else chk("wbeat", {lf.bus_wlast, lf.bus_wdata}, q_wb.pop_front());
        end
      end
      held_q = lf.bus_wvalid && !lf.bus_wready;
      held_v = {lf.bus_wlast, lf.bus_wdata};
      if (lf.mem_wen) begin
        chk("rready_mirror", lf.bus_rready, lf.mem_wready);
        if (lf.mem_wready) begin
          if (q_mw.size() == 0) flag("unexpected_memwrite");
          else chk("memwrite", {lf.mem_waddr, lf.mem_wdata}, q_mw.pop_front());
        end
      end
      if (lf.fetch_done) begin
        if (q_done.size() == 0) flag("unexpected_done");
        else begin
          longint e;
          e = q_done.pop_front();
          if (e >= 0) chk("done_cycle", $time - 5, e);
        end
      end
    end
  end

  // Local memory: always ready, data one cycle after the accepted read
  initial begin
    logic pend;
    logic [6:0] ra;
    lf.mem_rready = 1'b1; lf.mem_rvalid = 1'b0; lf.mem_rdata = '0;
    forever begin
      @(negedge clk);
      pend = lf.mem_ren && lf.mem_rready && rst_n;
      ra   = lf.mem_raddr;
      @(posedge clk); #1;
      lf.mem_rvalid = pend;
      lf.mem_rdata  = pend ? tbmem[ra] : '0;
    end
  end

  initial begin
    lf.mem_wready = 1'b1;
    forever begin
      @(posedge clk); #1;
      lf.mem_wready = wr_toggle ? !lf.mem_wready : 1'b1;
    end
  end

  // Bus write-ready: optionally stalls stall_len cycles on beat stall_beat
  initial begin
    int sent, scnt;
    logic xfer, held, clr;
    sent = 0; scnt = 0; lf.bus_wready = 1'b1;
    forever begin
      @(negedge clk);
      xfer = lf.bus_wvalid && lf.bus_wready;
      held = lf.bus_wvalid && !lf.bus_wready;
      clr  = lf.fetch_done || !rst_n;
      @(posedge clk); #1;
      if (clr) begin sent = 0; scnt = 0; end
      else begin
        if (xfer) sent++;
        if (held) scnt++;
      end
      lf.bus_wready = !(stall_en && sent == stall_beat && scnt < stall_len);
    end
  end

  task automatic issue(input logic [1:0] cmd, input logic [1:0] tag, input logic [31:0] addr,
                       output longint th);
    int k;
    lf.fetch_req = 1'b1; lf.fetch_cmd = cmd; lf.fetch_tag = tag; lf.fetch_addr = addr;
    k = 0;
    do begin @(negedge clk); k++; end while (!lf.fetch_gnt && k < 200);
    if (!lf.fetch_gnt) flag("grant_timeout");
    @(posedge clk); th = $time; #1;
    lf.fetch_req = 1'b0;
  endtask

  task automatic fill_expect(input logic [1:0] tag, input logic [31:0] al, input logic [31:0] base);
    q_bus.push_back({1'b0, al});
    for (int i = 0; i < LW; i++) q_mw.push_back({tag, 5'(i), base + 32'(i)});
  endtask

  task automatic fill_drive(input logic [31:0] base, input int rlast_beat);
    for (int i = 0; i < LW; i++) begin
      int k;
      lf.bus_rvalid = 1'b1; lf.bus_rdata = base + 32'(i); lf.bus_rlast = (i == rlast_beat);
      k = 0;
      do begin @(negedge clk); k++; end while (!(lf.bus_rvalid && lf.bus_rready) && k < 200);
      if (k >= 200) begin flag("rbeat_timeout"); break; end
      @(posedge clk); #1;
    end
    lf.bus_rvalid = 1'b0; lf.bus_rlast = 1'b0; lf.bus_rdata = '0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (q_done.size() != 0 && k < 2000);
    if (q_done.size() != 0) flag("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_ctl"},
        {lf.fetch_gnt, lf.mem_wpri, lf.bus_len, lf.bus_req, lf.bus_we, lf.mem_ren, lf.mem_wen,
         lf.bus_wvalid, lf.bus_wlast, lf.bus_rready, lf.fetch_done, lf.proto_err},
        {1'b1, 2'b01, 5'd31, 9'b0});
    chk({nm, "_bus_addr"}, lf.bus_addr, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    longint th, th2;
    int k;
    lf.fetch_req = 0; lf.fetch_cmd = 0; lf.fetch_tag = 0; lf.fetch_addr = 0;
    lf.bus_gnt = 1; lf.bus_rvalid = 0; lf.bus_rdata = 0; lf.bus_rlast = 0;
    for (int j = 0; j < 128; j++) tbmem[j] = 32'h5500_0000 | 32'(j);
    for (int i = 0; i < 32; i++) tbmem[32 + i] = 32'hA0 + 32'(i);
    rst_n = 1'b0;
    #2;
    check_reset_outs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill, zero-wait: tag 2, 0x1234_5678 -> 0x1234_5600, data 0..31
    fill_expect(2'd2, 32'h1234_5600, 32'h0);
    issue(2'b01, 2'd2, 32'h1234_5678, th);
    q_done.push_back(th + 33 * 10);
    fill_drive(32'h0, 31);
    wait_done();
    chk("proto_err_clean", lf.proto_err, 1'b0);

    // Writeback with 3-cycle stall on beat 5: tag 1 holds 0xA0+i
    stall_en = 1; stall_beat = 5; stall_len = 3;
    q_bus.push_back({1'b1, 32'h8000_0180});
    for (int i = 0; i < LW; i++) q_wb.push_back({(i == 31), 32'hA0 + 32'(i)});
    issue(2'b00, 2'd1, 32'h8000_01C4, th);
    q_done.push_back(-1);
    wait_done();
    stall_en = 0;

    // Writeback zero-wait: tag 3 holds 0x5500_0060+i, DONE 97 cycles after handshake
    q_bus.push_back({1'b1, 32'h0000_0F80});
    for (int i = 0; i < LW; i++) q_wb.push_back({(i == 31), 32'h5500_0060 + 32'(i)});
    issue(2'b00, 2'd3, 32'h0000_0FFF, th);
    q_done.push_back(th + 97 * 10);
    wait_done();

    // Fill with mem_wready toggling every cycle
    wr_toggle = 1;
    fill_expect(2'd0, 32'h0000_0080, 32'h100);
    issue(2'b01, 2'd0, 32'h0000_0080, th);
    q_done.push_back(-1);
    fill_drive(32'h100, 31);
    wait_done();
    wr_toggle = 0;
    chk("proto_err_after_toggle", lf.proto_err, 1'b0);

    // Early rlast on beat 10: sticky error, still 32 beats
    fill_expect(2'd3, 32'hFFFF_FF80, 32'h200);
    issue(2'b01, 2'd3, 32'hFFFF_FFFF, th);
    q_done.push_back(th + 33 * 10);
    fill_drive(32'h200, 10);
    wait_done();
    chk("proto_err_set", lf.proto_err, 1'b1);

    // Reserved command, then a fill granted in the cycle after fetch_done
    fill_expect(2'd2, 32'h4000_0000, 32'h400);
    issue(2'b10, 2'd0, 32'h0, th);
    lf.fetch_req = 1'b1; lf.fetch_cmd = 2'b01; lf.fetch_tag = 2'd2; lf.fetch_addr = 32'h4000_0010;
    q_done.push_back(th);
    @(negedge clk);
    chk("gnt_low_in_done", lf.fetch_gnt, 1'b0);
    chk("no_bus_req_reserved", lf.bus_req, 1'b0);
    @(negedge clk);
    chk("gnt_back_to_back", lf.fetch_gnt, 1'b1);
    @(posedge clk); th2 = $time; #1;
    lf.fetch_req = 1'b0;
    q_done.push_back(th2 + 33 * 10);
    fill_drive(32'h400, 31);
    wait_done();
    chk("proto_err_sticky", lf.proto_err, 1'b1);

    // Reset while beat 7 of a writeback is held in the send state
    stall_en = 1; stall_beat = 7; stall_len = 1000;
    q_bus.push_back({1'b1, 32'h0000_1000});
    for (int i = 0; i < 7; i++) q_wb.push_back({1'b0, 32'h5500_0040 + 32'(i)});
    issue(2'b00, 2'd2, 32'h0000_1000, th);
    k = 0;
    do begin @(negedge clk); k++; end while (!(lf.bus_wvalid && !lf.bus_wready) && k < 500);
    if (k >= 500) flag("beat7_hold_timeout");
    chk("beat7_held_data", lf.bus_wdata, 32'h5500_0047);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midwb_reset");
    chk("wb_beats_before_reset", q_wb.size(), 0);
    stall_en = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    fill_expect(2'd1, 32'h0000_2000, 32'h500);
    issue(2'b01, 2'd1, 32'h0000_2000, th);
    q_done.push_back(th + 33 * 10);
    fill_drive(32'h500, 31);
    wait_done();
    chk("proto_err_post_reset", lf.proto_err, 1'b0);

    repeat (3) @(negedge clk);
    chk("q_bus_empty", q_bus.size(), 0);
    chk("q_wb_empty", q_wb.size(), 0);
    chk("q_mw_empty", q_mw.size(), 0);
    chk("q_done_empty", q_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
